// File: rtl/imem_boot_responder_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// imem_pkg -- shared types and constants for the instruction-memory responder
// Revision: 1.0
//------------------------------------------------------------------------------
package imem_pkg;

  typedef enum logic [2:0] {
    LD_IDLE = 3'd0,
    LD_LEN0 = 3'd1,
    LD_LEN1 = 3'd2,
    LD_DATA = 3'd3,
    LD_DONE = 3'd4
  } imem_ld_state_t;

  localparam logic [31:0] IMEM_NOP    = 32'h0000_0013;
  localparam logic [31:0] IMEM_BUBBLE = 32'h0000_0000;
  localparam int          LD_LEN_W    = 16;

endpackage
`default_nettype wire

// File: rtl/imem_boot_responder_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// imem_boot_responder_if -- fetch read port plus boot-loader byte stream
// Revision: 1.0
//------------------------------------------------------------------------------
interface imem_boot_responder_if;
  import imem_pkg::*;

  logic [63:0]         im_addr;
  logic [31:0]         im_dout;
  logic                im_stall;
  logic                ld_start;
  logic                ld_valid;
  logic [7:0]          ld_byte;
  logic                ld_ready;
  logic                ld_done;
  logic                ld_err;
  logic [LD_LEN_W-1:0] ld_words;

  modport master (
    output im_addr, ld_start, ld_valid, ld_byte,
    input  im_dout, im_stall, ld_ready, ld_done, ld_err, ld_words
  );

  modport slave (
    input  im_addr, ld_start, ld_valid, ld_byte,
    output im_dout, im_stall, ld_ready, ld_done, ld_err, ld_words
  );

endinterface
`default_nettype wire

// File: rtl/imem_boot_responder_packer.sv
`default_nettype none
//------------------------------------------------------------------------------
// imem_word_packer -- assembles four accepted bytes into a little-endian word
// Revision: 1.0
//------------------------------------------------------------------------------
module imem_word_packer
  import imem_pkg::*;
(
  input  wire logic        clk,
  input  wire logic        reset,
  input  wire logic        clr_i,
  input  wire logic        en_i,
  input  wire logic [7:0]  byte_i,
  output logic      [31:0] word_o,
  output logic             word_valid_o
);

  logic [1:0]  lane_q, lane_d;
  logic [23:0] acc_q,  acc_d;

  always_comb begin
    lane_d = lane_q;
    acc_d  = acc_q;
    if (clr_i) begin
      lane_d = '0;
      acc_d  = '0;
    end else if (en_i) begin
      lane_d = lane_q + 2'd1;
      case (lane_q)
        2'd0:    acc_d[7:0]   = byte_i;
        2'd1:    acc_d[15:8]  = byte_i;
        2'd2:    acc_d[23:16] = byte_i;
        default: acc_d        = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lane_q <= '0;
      acc_q  <= '0;
    end else begin
      lane_q <= lane_d;
      acc_q  <= acc_d;
    end
  end

  // The 4th byte completes the word on the same edge it is accepted.
  assign word_o       = {byte_i, acc_q};
  assign word_valid_o = en_i && (lane_q == 2'd3);

endmodule
`default_nettype wire

// File: rtl/imem_boot_responder.sv
`default_nettype none
//------------------------------------------------------------------------------
// imem_boot_responder -- fetch-stage instruction memory with byte-stream boot loader
// Revision: 1.0
//------------------------------------------------------------------------------
module imem_boot_responder
  import imem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input wire logic              clk,
  input wire logic              reset,
  imem_boot_responder_if.slave  bus
);

  localparam logic [31:0] C_DEPTH = 32'(DEPTH_WORDS);

  imem_ld_state_t      state_q;
  logic [LD_LEN_W-1:0] len_q;
  logic [LD_LEN_W-1:0] wr_ptr_q;
  logic [LD_LEN_W-1:0] words_q;
  logic                stall_q;
  logic                ready_q;
  logic                done_q;
  logic                err_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic                w_accept;
  logic                w_start;
  logic                w_pack_en;
  logic                w_word_valid;
  logic [31:0]         w_word;
  logic [LD_LEN_W-1:0] w_hdr_len;
  logic                w_in_range;
  logic                w_last_word;
  logic                w_we;
  logic                w_unused_addr_lsb;

  assign w_accept    = bus.ld_valid && ready_q;
  assign w_start     = bus.ld_start && (state_q == LD_IDLE);
  assign w_pack_en   = w_accept && (state_q == LD_DATA);
  assign w_hdr_len   = {bus.ld_byte, len_q[7:0]};
  assign w_in_range  = 32'(wr_ptr_q) < C_DEPTH;
  assign w_last_word = (wr_ptr_q == (len_q - LD_LEN_W'(1)));
  // Words past the array end are counted for stream framing but never stored.
  assign w_we        = w_word_valid && w_in_range;

  imem_word_packer u_packer (
    .clk          (clk),
    .reset        (reset),
    .clr_i        (w_start),
    .en_i         (w_pack_en),
    .byte_i       (bus.ld_byte),
    .word_o       (w_word),
    .word_valid_o (w_word_valid)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= LD_IDLE;
      len_q    <= '0;
      wr_ptr_q <= '0;
      words_q  <= '0;
      stall_q  <= 1'b0;
      ready_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        LD_IDLE: begin
          if (bus.ld_start) begin
            state_q  <= LD_LEN0;
            stall_q  <= 1'b1;
            ready_q  <= 1'b1;
            err_q    <= 1'b0;
            words_q  <= '0;
            wr_ptr_q <= '0;
            len_q    <= '0;
          end
        end
        LD_LEN0: begin
          if (w_accept) begin
            len_q[7:0] <= bus.ld_byte;
            state_q    <= LD_LEN1;
          end
        end
        LD_LEN1: begin
          if (w_accept) begin
            len_q[15:8] <= bus.ld_byte;
            if (32'(w_hdr_len) > C_DEPTH) begin
              err_q <= 1'b1;
            end
            if (w_hdr_len == '0) begin
              state_q <= LD_DONE;
              ready_q <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= LD_DATA;
            end
          end
        end
        LD_DATA: begin
          if (w_word_valid) begin
            wr_ptr_q <= wr_ptr_q + LD_LEN_W'(1);
            if (w_in_range) begin
              words_q <= words_q + LD_LEN_W'(1);
            end
            if (w_last_word) begin
              state_q <= LD_DONE;
              ready_q <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        LD_DONE: begin
          state_q <= LD_IDLE;
          stall_q <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= LD_IDLE;
          stall_q <= 1'b0;
          ready_q <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // The array is intentionally not reset; boot contents survive a reset.
  always_ff @(posedge clk) begin
    if (w_we) begin
      mem[wr_ptr_q[IDX_W-1:0]] <= w_word;
    end
  end

  always_comb begin
    bus.im_dout = mem[bus.im_addr[IDX_W+1:2]];
    if (stall_q) begin
      bus.im_dout = IMEM_BUBBLE;
    end else if (|bus.im_addr[63:IDX_W+2]) begin
      bus.im_dout = IMEM_NOP;
    end
  end

  assign w_unused_addr_lsb = ^bus.im_addr[1:0];

  assign bus.im_stall = stall_q;
  assign bus.ld_ready = ready_q;
  assign bus.ld_done  = done_q;
  assign bus.ld_err   = err_q;
  assign bus.ld_words = words_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_boot_responder.sv
`default_nettype none
//------------------------------------------------------------------------------
// tb_imem_boot_responder -- two depths driven in lockstep against a word-level model
// Revision: 1.0
//------------------------------------------------------------------------------
module tb_imem_boot_responder;
  import imem_pkg::*;

  typedef logic [7:0] byte_q_t [$];

  localparam int NDUT    = 2;
  localparam int DEPTH_A = 64;
  localparam int DEPTH_B = 4;
  localparam int MAXD    = 64;
  localparam int BUDGET  = 20000;

  logic        clk      = 1'b0;
  logic        reset    = 1'b0;
  logic [63:0] im_addr  = '0;
  logic        ld_start = 1'b0;
  logic        ld_valid = 1'b0;
  logic [7:0]  ld_byte  = '0;

  int vectors     = 0;
  int miscompares = 0;

  imem_boot_responder_if ifa ();
  imem_boot_responder_if ifb ();

  assign ifa.im_addr  = im_addr;
  assign ifa.ld_start = ld_start;
  assign ifa.ld_valid = ld_valid;
  assign ifa.ld_byte  = ld_byte;
  assign ifb.im_addr  = im_addr;
  assign ifb.ld_start = ld_start;
  assign ifb.ld_valid = ld_valid;
  assign ifb.ld_byte  = ld_byte;

  imem_boot_responder #(.DEPTH_WORDS(DEPTH_A)) u_dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ifa.slave)
  );

  imem_boot_responder #(.DEPTH_WORDS(DEPTH_B)) u_dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ifb.slave)
  );

  logic [31:0] o_dout  [NDUT];
  logic        o_stall [NDUT];
  logic        o_ready [NDUT];
  logic        o_done  [NDUT];
  logic        o_err   [NDUT];
  logic [15:0] o_words [NDUT];

  assign o_dout[0]  = ifa.im_dout;
  assign o_stall[0] = ifa.im_stall;
  assign o_ready[0] = ifa.ld_ready;
  assign o_done[0]  = ifa.ld_done;
  assign o_err[0]   = ifa.ld_err;
  assign o_words[0] = ifa.ld_words;
  assign o_dout[1]  = ifb.im_dout;
  assign o_stall[1] = ifb.im_stall;
  assign o_ready[1] = ifb.ld_ready;
  assign o_done[1]  = ifb.ld_done;
  assign o_err[1]   = ifb.ld_err;
  assign o_words[1] = ifb.ld_words;

  int          depth_c [NDUT] = '{DEPTH_A, DEPTH_B};
  logic [31:0] mdl_mem   [NDUT][MAXD];
  bit          mdl_vld   [NDUT][MAXD];
  int          mdl_words [NDUT];
  bit          mdl_err   [NDUT];

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic make_stream(input int n, output byte_q_t q);
    logic [15:0] n16;
    n16 = 16'(n);
    q = {};
    q.push_back(n16[7:0]);
    q.push_back(n16[15:8]);
    for (int k = 0; k < 4 * n; k++) q.push_back(8'($urandom_range(255)));
  endtask

  // Drives one complete load; the model is updated from the byte stream up front.
  task automatic run_load(input byte_q_t b, input int gap_pct, input bit poke_start, input string tag);
    int n, idx, cyc;
    bit v;
    logic [31:0] w;
    n = int'({b[1], b[0]});
    for (int i = 0; i < n; i++) begin
      w = {b[2+4*i+3], b[2+4*i+2], b[2+4*i+1], b[2+4*i]};
      for (int d = 0; d < NDUT; d++) begin
        if (i < depth_c[d]) begin
          mdl_mem[d][i] = w;
          mdl_vld[d][i] = 1'b1;
        end
      end
    end
    for (int d = 0; d < NDUT; d++) begin
      mdl_words[d] = (n < depth_c[d]) ? n : depth_c[d];
      mdl_err[d]   = (n > depth_c[d]);
    end

    ld_start = 1'b1;
    step();
    ld_start = 1'b0;
    idx = 0;
    cyc = 0;
    while (idx < b.size() && cyc < BUDGET) begin
      for (int d = 0; d < NDUT; d++) begin
        vectors++;
        if (o_stall[d] !== 1'b1 || o_ready[d] !== 1'b1 || o_done[d] !== 1'b0 || o_dout[d] !== IMEM_BUBBLE) begin
          miscompares++;
          $display("FAIL %s busy dut%0d byte%0d: stall=%b ready=%b done=%b dout=%h, required 1 1 0 %h",
                   tag, d, idx, o_stall[d], o_ready[d], o_done[d], o_dout[d], IMEM_BUBBLE);
        end
      end
      v        = ($urandom_range(99) >= gap_pct);
      ld_valid = v;
      ld_byte  = b[idx];
      ld_start = poke_start && (idx >= 6) && (idx < 10);
      im_addr  = 64'($urandom_range(255));
      step();
      if (v) idx++;
      cyc++;
    end
    ld_valid = 1'b0;
    ld_start = 1'b0;
    vectors++;
    if (idx < b.size()) begin
      miscompares++;
      $display("FAIL %s timeout: accepted %0d bytes, required %0d", tag, idx, b.size());
    end

    for (int d = 0; d < NDUT; d++) begin
      vectors++;
      if (o_stall[d] !== 1'b1 || o_ready[d] !== 1'b0 || o_done[d] !== 1'b1 ||
          o_words[d] !== 16'(mdl_words[d]) || o_err[d] !== mdl_err[d]) begin
        miscompares++;
        $display("FAIL %s done_cycle dut%0d: stall=%b ready=%b done=%b words=%0d err=%b, required 1 0 1 %0d %b",
                 tag, d, o_stall[d], o_ready[d], o_done[d], o_words[d], o_err[d], mdl_words[d], mdl_err[d]);
      end
    end
    step();
    for (int d = 0; d < NDUT; d++) begin
      vectors++;
      if (o_stall[d] !== 1'b0 || o_ready[d] !== 1'b0 || o_done[d] !== 1'b0 ||
          o_words[d] !== 16'(mdl_words[d]) || o_err[d] !== mdl_err[d]) begin
        miscompares++;
        $display("FAIL %s after_done dut%0d: stall=%b ready=%b done=%b words=%0d err=%b, required 0 0 0 %0d %b",
                 tag, d, o_stall[d], o_ready[d], o_done[d], o_words[d], o_err[d], mdl_words[d], mdl_err[d]);
      end
    end
  endtask

  task automatic read_back(input string tag);
    for (int i = 0; i < MAXD; i++) begin
      im_addr = 64'(4 * i + $urandom_range(3));
      #1;
      for (int d = 0; d < NDUT; d++) begin
        if (i >= depth_c[d]) begin
          vectors++;
          if (o_dout[d] !== IMEM_NOP) begin
            miscompares++;
            $display("FAIL %s oor dut%0d addr=%h: dout=%h, required %h", tag, d, im_addr, o_dout[d], IMEM_NOP);
          end
        end else if (mdl_vld[d][i]) begin
          vectors++;
          if (o_dout[d] !== mdl_mem[d][i]) begin
            miscompares++;
            $display("FAIL %s word dut%0d addr=%h: dout=%h, required %h", tag, d, im_addr, o_dout[d], mdl_mem[d][i]);
          end
        end
      end
    end
    step();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) step();
    for (int d = 0; d < NDUT; d++) begin
      vectors++;
      if (o_stall[d] !== 1'b0 || o_ready[d] !== 1'b0 || o_done[d] !== 1'b0 ||
          o_err[d] !== 1'b0 || o_words[d] !== 16'd0) begin
        miscompares++;
        $display("FAIL reset dut%0d: stall=%b ready=%b done=%b err=%b words=%0d, required all zero",
                 d, o_stall[d], o_ready[d], o_done[d], o_err[d], o_words[d]);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    step();
  endtask

  task automatic test_basic();
    byte_q_t q;
    logic [31:0] exp_w [3];
    logic [63:0] addr_t [3];
    q = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
    run_load(q, 0, 1'b0, "basic");
    exp_w  = '{32'h0010_0513, 32'h0020_0593, 32'h0020_0593};
    addr_t = '{64'd0, 64'd4, 64'd5};
    for (int k = 0; k < 3; k++) begin
      im_addr = addr_t[k];
      #1;
      for (int d = 0; d < NDUT; d++) begin
        vectors++;
        if (o_dout[d] !== exp_w[k]) begin
          miscompares++;
          $display("FAIL basic_read dut%0d addr=%0d: dout=%h, required %h", d, addr_t[k], o_dout[d], exp_w[k]);
        end
      end
    end
    step();
    read_back("basic");
  endtask

  task automatic test_zero_len();
    byte_q_t q;
    q = '{8'h00, 8'h00};
    run_load(q, 0, 1'b0, "zero_len");
    read_back("zero_len");
  endtask

  task automatic test_overflow();
    byte_q_t q;
    make_stream(6, q);
    run_load(q, 0, 1'b0, "ovf6");
    read_back("ovf6");
    make_stream(DEPTH_A + 2, q);
    run_load(q, 0, 1'b0, "ovf66");
    read_back("ovf66");
  endtask

  task automatic test_reads();
    logic [63:0] addr_t [4];
    logic [31:0] exp_a [4];
    logic [31:0] exp_b [4];
    addr_t = '{64'(4 * DEPTH_A), 64'(4 * DEPTH_B), 64'hFFFF_FFFF_FFFF_FFFF, 64'h1_0000_0000};
    exp_a  = '{IMEM_NOP, mdl_mem[0][DEPTH_B], IMEM_NOP, IMEM_NOP};
    exp_b  = '{IMEM_NOP, IMEM_NOP, IMEM_NOP, IMEM_NOP};
    for (int k = 0; k < 4; k++) begin
      im_addr = addr_t[k];
      #1;
      vectors++;
      if (o_dout[0] !== exp_a[k]) begin
        miscompares++;
        $display("FAIL reads dut0 addr=%h: dout=%h, required %h", addr_t[k], o_dout[0], exp_a[k]);
      end
      vectors++;
      if (o_dout[1] !== exp_b[k]) begin
        miscompares++;
        $display("FAIL reads dut1 addr=%h: dout=%h, required %h", addr_t[k], o_dout[1], exp_b[k]);
      end
    end
    step();
  endtask

  task automatic test_reset_mid_load();
    byte_q_t q;
    make_stream(3, q);
    ld_start = 1'b1;
    step();
    ld_start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      ld_valid = 1'b1;
      ld_byte  = q[k];
      step();
    end
    ld_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    for (int d = 0; d < NDUT; d++) begin
      mdl_mem[d][0] = {q[5], q[4], q[3], q[2]};
      mdl_vld[d][0] = 1'b1;
      vectors++;
      if (o_stall[d] !== 1'b0 || o_ready[d] !== 1'b0 || o_done[d] !== 1'b0 ||
          o_err[d] !== 1'b0 || o_words[d] !== 16'd0) begin
        miscompares++;
        $display("FAIL mid_reset dut%0d: stall=%b ready=%b done=%b err=%b words=%0d, required all zero",
                 d, o_stall[d], o_ready[d], o_done[d], o_err[d], o_words[d]);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    step();
    read_back("mid_reset");
  endtask

  task automatic test_ignored_start_gaps();
    byte_q_t q1, q2;
    make_stream(5, q1);
    make_stream(5, q2);
    run_load(q1, 0, 1'b0, "gapfree");
    read_back("gapfree");
    run_load(q2, 40, 1'b1, "gaps_poke");
    read_back("gaps_poke");
    run_load(q1, 50, 1'b1, "gaps_repeat");
    read_back("gaps_repeat");
  endtask

  task automatic test_random();
    byte_q_t q;
    for (int it = 0; it < 8; it++) begin
      make_stream($urandom_range(7), q);
      run_load(q, $urandom_range(50), 1'($urandom_range(1)), "random");
      read_back("random");
    end
  endtask

  initial begin
    for (int d = 0; d < NDUT; d++) begin
      for (int i = 0; i < MAXD; i++) begin
        mdl_mem[d][i] = '0;
        mdl_vld[d][i] = 1'b0;
      end
      mdl_words[d] = 0;
      mdl_err[d]   = 1'b0;
    end
    test_reset();
    test_basic();
    test_zero_len();
    test_overflow();
    test_reads();
    test_reset_mid_load();
    test_ignored_start_gaps();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
